// File: rtl/ram_param.sv
// Parametrised single-port RAM with post-reset clear sweep and optional registered read.
module ram_param #(
    parameter int unsigned      WIDTH       = 16,
    parameter int unsigned      ADDR_W      = 14,
    parameter int unsigned      READ_REG    = 0,
    parameter int unsigned      CLEAR_EN    = 1,
    parameter logic [WIDTH-1:0] CLEAR_VALUE = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WIDTH-1:0]  in,
    input  logic [ADDR_W-1:0] addr,
    input  logic              load,
    output logic [WIDTH-1:0]  out,
    output logic              busy
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned CNT_W = ADDR_W + 1;

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_IDLE  = 1'b1
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   clr_cnt;
    logic               mem_we;
    logic [ADDR_W-1:0]  mem_waddr;
    logic [WIDTH-1:0]   mem_wdata;
    logic [WIDTH-1:0]   mem [DEPTH];

    // State register: sweep restarts after every reset when enabled
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= (CLEAR_EN != 0) ? S_CLEAR : S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: leave CLEAR on the edge that writes the last word
    always_comb begin
        state_nxt = state;
        if ((state == S_CLEAR) && (clr_cnt == CNT_W'(DEPTH - 1))) begin
            state_nxt = S_IDLE;
        end
    end

    // Outputs/write steering: sweep owns the array while busy; reset blocks all writes
    always_comb begin
        busy      = 1'b0;
        mem_we    = 1'b0;
        mem_waddr = addr;
        mem_wdata = in;
        case (state)
            S_CLEAR: begin
                busy      = 1'b1;
                mem_we    = ~reset;
                mem_waddr = clr_cnt[ADDR_W-1:0];
                mem_wdata = CLEAR_VALUE;
            end
            S_IDLE: begin
                mem_we = load & ~reset;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // Sweep address counter; one spare bit so it never wraps
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clr_cnt <= '0;
        end else if (state == S_CLEAR) begin
            clr_cnt <= clr_cnt + CNT_W'(1);
        end
    end

    // Storage array; contents survive reset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    generate
        if (READ_REG != 0) begin : g_rd_reg
            logic [WIDTH-1:0] out_q;

            // Registered read-first port, held at zero during the sweep
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    out_q <= '0;
                end else if (busy) begin
                    out_q <= '0;
                end else begin
                    out_q <= mem[addr];
                end
            end

            assign out = out_q;
        end else begin : g_rd_comb
            assign out = busy ? '0 : mem[addr];
        end
    endgenerate

endmodule
